uart_tx_frame_engine: RTL

Parametrised UART transmit frame engine: accepts one data word per valid/ready handshake and serialises it as start bit, DATA_W data bits (LSB first), an optional parity bit or optional CRC field, and one or two stop bits. It owns the bit-period counter, bit counter, shift register and per-frame CRC accumulator. It sits between the TX buffer/register interface and the pad, and replaces the fixed-8-bit TX control path with per-frame runtime modes.

---
 rtl/uart_tx_frame_engine_if.sv | 24 ++
 rtl/uart_tx_frame_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_engine_if.sv
// Request side of the UART TX frame engine: one data word plus the
// per-frame mode bits, offered under a valid/ready handshake.
interface uart_tx_frame_engine_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic [DATA_W-1:0] tx_data_i;
    logic [1:0]        parity_mode_i;
    logic              crc_en_i;
    logic              stop2_i;

    // Producer of words (TX buffer / register block)
    modport master (
        output tx_valid_i, tx_data_i, parity_mode_i, crc_en_i, stop2_i,
        input  tx_ready_o
    );

    // The frame engine
    modport slave (
        input  tx_valid_i, tx_data_i, parity_mode_i, crc_en_i, stop2_i,
        output tx_ready_o
    );
endinterface

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: start bit, DATA_W data bits LSB first,
// optional parity bit or CRC field (MSB first), then one or two stop bits.
// Mode bits are latched with the word so each frame carries its own format.
module uart_tx_frame_engine #(
    parameter int          DATA_W       = 8,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          CRC_W        = 8,
    parameter int unsigned CRC_POLY     = 'h07,
    parameter int unsigned CRC_INIT     = 'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    uart_tx_frame_engine_if.slave bus,
    output logic                  tx_o,
    output logic                  tx_busy_o,
    output logic                  tx_done_o,
    output logic [2:0]            state_o,
    output logic                  state_change_o
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = 5;  // covers up to 16 CRC bits and 9 data bits

    localparam logic [CW-1:0]    CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]    DLAST    = BW'(DATA_W - 1);
    localparam logic [BW-1:0]    CLAST    = BW'(CRC_W - 1);
    localparam logic [31:0]      POLY32   = 32'(CRC_POLY);
    localparam logic [31:0]      INIT32   = 32'(CRC_INIT);
    localparam logic [CRC_W-1:0] POLY     = POLY32[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT     = INIT32[CRC_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_CRC    = 3'd4,
        S_STOP   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    state_e              prev_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic                par_q, par_d;
    logic [1:0]          pmode_q, pmode_d;
    logic                crc_en_q, crc_en_d;
    logic                stop2_q, stop2_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                chg_q;

    logic                accept;
    logic                wrap;
    logic                cur_bit;
    logic                crc_fb;
    logic [CRC_W-1:0]    crc_nx;

    assign accept  = bus.tx_valid_i && (state_q == S_IDLE);
    assign wrap    = (cnt_q == CNT_MAX);
    assign cur_bit = shift_q[0];
    assign crc_fb  = crc_q[CRC_W-1] ^ cur_bit;
    assign crc_nx  = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_fb ? POLY : '0);

    // Next-state and line value; everything advances on bit-period wraps
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        crc_d    = crc_q;
        par_d    = par_q;
        pmode_d  = pmode_q;
        crc_en_d = crc_en_q;
        stop2_d  = stop2_q;
        tx_d     = tx_q;
        done_d   = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    cnt_d    = '0;
                    bit_d    = '0;
                    shift_d  = bus.tx_data_i;
                    crc_d    = INIT;
                    par_d    = 1'b0;
                    pmode_d  = bus.parity_mode_i;
                    crc_en_d = bus.crc_en_i;
                    stop2_d  = bus.stop2_i;
                end
            end
            S_START: begin
                if (wrap) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (wrap) begin
                    crc_d   = crc_nx;
                    par_d   = par_q ^ cur_bit;
                    shift_d = shift_q >> 1;
                    if (bit_q == DLAST) begin
                        bit_d = '0;
                        if (crc_en_q) begin
                            state_d = S_CRC;
                            tx_d    = crc_nx[CRC_W-1];
                        end else if (pmode_q == 2'b01 || pmode_q == 2'b10) begin
                            state_d = S_PARITY;
                            // odd mode (2'b10) inverts the running XOR
                            tx_d    = par_q ^ cur_bit ^ pmode_q[1];
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tx_d  = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (wrap) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_CRC: begin
                if (wrap) begin
                    crc_d = {crc_q[CRC_W-2:0], 1'b0};
                    if (bit_q == CLAST) begin
                        state_d = S_STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tx_d  = crc_q[CRC_W-2];
                    end
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (wrap) begin
                    if (stop2_q && bit_q == '0) begin
                        bit_d = BW'(1);
                    end else begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any frame
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            prev_q   <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            crc_q    <= '0;
            par_q    <= 1'b0;
            pmode_q  <= 2'b00;
            crc_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= state_q;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            crc_q    <= crc_d;
            par_q    <= par_d;
            pmode_q  <= pmode_d;
            crc_en_q <= crc_en_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            // compares current to previous state, so it trails state_o
            chg_q    <= (state_q != prev_q);
        end
    end

    assign bus.tx_ready_o = (state_q == S_IDLE);
    assign tx_busy_o      = (state_q != S_IDLE);
    assign tx_o           = tx_q;
    assign tx_done_o      = done_q;
    assign state_o        = state_q;
    assign state_change_o = chg_q;

endmodule
